// File: rtl/uart_tx_ctrl_if.sv
// Data-memory bus port of the UART transmit controller.
// The CPU side drives select, strobe, address and store data; the controller returns load data.
interface uart_tx_ctrl_if;
  logic        sel;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output sel, we, addr, wdata, input rdata);
  modport slave  (input sel, we, addr, wdata, output rdata);
endinterface

// File: rtl/uart_tx_ctrl.sv
// Memory-mapped 8N1 UART transmitter: a byte FIFO fed by CPU stores, drained by a
// baud-rate state machine onto uart_tx.
//
// state | meaning
// IDLE  | line high, waiting for a byte in the FIFO
// START | start bit (low) for one bit period
// DATA  | eight data bits, LSB first, one bit period each
// STOP  | stop bit (high); pops the next byte directly into START if one is waiting
module uart_tx_ctrl #(
  parameter int DIV_RESET  = 434,
  parameter int FIFO_DEPTH = 16
) (
  input  logic           CLK,
  input  logic           RST,
  uart_tx_ctrl_if.slave  bus,
  output logic           uart_tx,
  output logic           tx_busy
);

  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [15:0] DIV_INIT = 16'(DIV_RESET);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          overflow;
  logic [15:0]   divisor;
  logic [15:0]   bit_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic [7:0]    head;

  logic full;
  logic empty;
  logic wr_txdata;
  logic wr_status;
  logic wr_div;
  logic push;
  logic pop;
  logic bit_done;
  logic [8:0] count_ext;
  logic [7:0] count_sat;

  // Upper store-data bits have no register behind them.
  logic unused_wdata;
  assign unused_wdata = ^bus.wdata[31:16];

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign wr_txdata = bus.sel & bus.we & (bus.addr == 2'd0);
  assign wr_status = bus.sel & bus.we & (bus.addr == 2'd1);
  assign wr_div    = bus.sel & bus.we & (bus.addr == 2'd2);
  // Full is judged on the pre-edge count, so a push while full is dropped even
  // if the FSM pops on the same edge.
  assign push      = wr_txdata & ~full;
  assign bit_done  = (bit_cnt == 16'd0);
  assign pop       = ~empty & ((state == IDLE) | ((state == STOP) & bit_done));
  assign head      = mem[rd_ptr];
  assign tx_busy   = (state != IDLE) | ~empty;
  assign count_ext = 9'(count);
  assign count_sat = count_ext[8] ? 8'hFF : count_ext[7:0];

  // Configuration registers: divisor with a floor of 2, sticky overflow flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      divisor  <= DIV_INIT;
      overflow <= 1'b0;
    end else begin
      if (wr_div) begin
        divisor <= (bus.wdata[15:0] < 16'd2) ? 16'd2 : bus.wdata[15:0];
      end
      if (wr_txdata & full) begin
        overflow <= 1'b1;
      end else if (wr_status & bus.wdata[3]) begin
        overflow <= 1'b0;
      end
    end
  end

  // FIFO storage; validity is tracked by the pointers and count, so no reset here.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= bus.wdata[7:0];
    end
  end

  // FIFO pointers wrap modulo the depth; count separates full from empty.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Frame sequencer; bit timer is a down-counter reloaded from the live divisor,
  // so a divisor change takes effect at the next bit boundary.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      uart_tx <= 1'b1;
      bit_cnt <= 16'd0;
      bit_idx <= 3'd0;
      shift   <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          uart_tx <= 1'b1;
          if (pop) begin
            shift   <= head;
            bit_cnt <= divisor - 16'd1;
            uart_tx <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          if (bit_done) begin
            bit_idx <= 3'd0;
            bit_cnt <= divisor - 16'd1;
            uart_tx <= shift[0];
            state   <= DATA;
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        DATA: begin
          if (bit_done) begin
            bit_cnt <= divisor - 16'd1;
            if (bit_idx == 3'd7) begin
              uart_tx <= 1'b1;
              state   <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= {1'b0, shift[7:1]};
              uart_tx <= shift[1];
            end
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        STOP: begin
          if (bit_done) begin
            if (pop) begin
              shift   <= head;
              bit_cnt <= divisor - 16'd1;
              uart_tx <= 1'b0;
              state   <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        default: begin
          uart_tx <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

  // Load data mux; combinational, reflects pre-edge state.
  always_comb begin
    bus.rdata = 32'd0;
    if (bus.sel && !bus.we) begin
      case (bus.addr)
        2'd1:    bus.rdata = {16'd0, count_sat, 4'd0, overflow, tx_busy, empty, full};
        2'd2:    bus.rdata = {16'd0, divisor};
        default: bus.rdata = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: directed bus traffic with expected frames and load data
// queued by the stimulus and checked by independent line and bus monitors.
module tb_uart_tx_ctrl;

  typedef struct {
    logic [7:0] data;
    int         len_lo;
    int         len_hi;
    int         sw;
    bit         contig;
    int         start_cyc;
  } frame_t;

  typedef struct {
    logic [31:0] val;
    logic [1:0]  addr;
    int          id;
  } rd_t;

  logic CLK;
  logic RST;
  logic uart_tx;
  logic tx_busy;

  uart_tx_ctrl_if bif ();

  uart_tx_ctrl dut (
    .CLK     (CLK),
    .RST     (RST),
    .bus     (bif),
    .uart_tx (uart_tx),
    .tx_busy (tx_busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int frames_done = 0;
  int nf = 0;
  int rd_id = 0;
  int last_end = -100;

  frame_t exp_frames[$];
  rd_t    rd_q[$];

  frame_t     cur;
  bit         mon_active = 0;
  bit         mon_bogus = 0;
  int         mon_k = 0;
  int         mon_r = 0;
  int         mon_err = 0;
  int         mon_start = 0;
  logic [7:0] mon_d;
  logic       exp_bit;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic exp_frame(input logic [7:0] d, input int lo, input int hi, input int sw,
                           input bit contig, input int start_cyc);
    frame_t f;
    f.data = d; f.len_lo = lo; f.len_hi = hi; f.sw = sw;
    f.contig = contig; f.start_cyc = start_cyc;
    exp_frames.push_back(f);
    nf++;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bif.sel = 1'b1; bif.we = 1'b1; bif.addr = a; bif.wdata = d;
    @(posedge CLK); #1;
    bif.sel = 1'b0; bif.we = 1'b0; bif.wdata = 32'd0;
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [31:0] exp);
    rd_t r;
    r.val = exp; r.addr = a; r.id = rd_id;
    rd_id++;
    rd_q.push_back(r);
    bif.sel = 1'b1; bif.we = 1'b0; bif.addr = a;
    @(posedge CLK); #1;
    bif.sel = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    int t;
    t = 0;
    while (frames_done < n && t < 5000) begin
      @(negedge CLK); #1;
      t++;
    end
    checks++;
    if (frames_done < n) begin
      errors++;
      $display("FAIL wait_frames done=%0d required=%0d", frames_done, n);
    end
  endtask

  // Load monitor: every bus read is compared with the next queued expectation.
  always @(negedge CLK) begin
    if (!RST && bif.sel && !bif.we) begin
      checks++;
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL read_unexpected addr=%0d got=%08h", bif.addr, bif.rdata);
      end else begin
        rd_t r;
        r = rd_q.pop_front();
        if (bif.rdata !== r.val || bif.addr !== r.addr) begin
          errors++;
          $display("FAIL read id=%0d addr=%0d got=%08h exp=%08h", r.id, r.addr, bif.rdata, r.val);
        end
      end
    end
  end

  // Line monitor: each cycle of a frame is compared with the expected level and bit length.
  always @(negedge CLK) begin
    cyc++;
    if (RST) begin
      mon_active = 0;
    end else begin
      if (!mon_active && uart_tx === 1'b0) begin
        mon_active = 1; mon_k = 0; mon_err = 0; mon_bogus = 0; mon_start = cyc;
        if (exp_frames.size() == 0) begin
          mon_bogus = 1;
          checks++; errors++;
          $display("FAIL unexpected_frame start_cycle=%0d required=no frame", cyc);
          cur.data = 8'h00; cur.len_lo = 1; cur.len_hi = 1; cur.sw = 10;
          cur.contig = 0; cur.start_cyc = -1;
        end else begin
          cur = exp_frames.pop_front();
        end
        if (cur.contig && cyc != last_end + 1) mon_err++;
        if (cur.start_cyc >= 0 && cyc != cur.start_cyc) mon_err++;
        mon_r = (cur.sw == 0) ? cur.len_hi : cur.len_lo;
      end
      if (mon_active) begin
        mon_d = cur.data;
        if (mon_k == 0)      exp_bit = 1'b0;
        else if (mon_k == 9) exp_bit = 1'b1;
        else                 exp_bit = mon_d[mon_k-1];
        if (uart_tx !== exp_bit) mon_err++;
        mon_r--;
        if (mon_r == 0) begin
          mon_k++;
          if (mon_k == 10) begin
            mon_active = 0;
            last_end = cyc;
            frames_done++;
            if (!mon_bogus) begin
              checks++;
              if (mon_err != 0) begin
                errors++;
                $display("FAIL frame data=%02h start=%0d bad_samples=%0d required=0",
                         cur.data, mon_start, mon_err);
              end
            end
          end else begin
            mon_r = (mon_k >= cur.sw) ? cur.len_hi : cur.len_lo;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog time=%0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    RST = 1'b1;
    bif.sel = 1'b0; bif.we = 1'b0; bif.addr = 2'd0; bif.wdata = 32'd0;
    #12;
    chk("reset_uart_tx", 32'(uart_tx), 32'd1);
    chk("reset_busy", 32'(tx_busy), 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;
    chk("rdata_nosel", bif.rdata, 32'd0);
    bus_read(2'd1, 32'h0000_0002);
    bus_read(2'd2, 32'd434);
    bus_read(2'd0, 32'd0);
    bus_read(2'd3, 32'd0);

    // single byte at divisor 4, start bit two edges after the store
    bus_write(2'd2, 32'd4);
    bus_write(2'd0, 32'h55);
    exp_frame(8'h55, 4, 4, 10, 0, cyc + 2);
    wait_frames(nf);
    chk("busy_last_stop_cycle", 32'(tx_busy), 32'd1);
    @(posedge CLK); #1;
    chk("busy_after_stop", 32'(tx_busy), 32'd0);
    chk("line_idle", 32'(uart_tx), 32'd1);

    // back-to-back frames behind a leading byte
    bus_write(2'd2, 32'd2);
    bus_write(2'd0, 32'h3C);
    exp_frame(8'h3C, 2, 2, 10, 0, -1);
    exp_frame(8'h00, 2, 2, 10, 1, -1);
    exp_frame(8'hFF, 2, 2, 10, 1, -1);
    exp_frame(8'hA5, 2, 2, 10, 1, -1);
    bus_write(2'd0, 32'h00);
    bus_write(2'd0, 32'hFF);
    bus_write(2'd0, 32'hA5);
    bus_read(2'd1, 32'h0000_0304);
    wait_frames(nf - 3);
    @(posedge CLK); #1;
    bus_read(2'd1, 32'h0000_0204);
    wait_frames(nf);

    // overflow with a stalled sequencer, then speed up to drain
    bus_write(2'd2, 32'd1000);
    for (int i = 0; i < 17; i++) begin
      exp_frame(8'(8'h10 + i), (i == 0) ? 1000 : 2, 2, (i == 0) ? 1 : 10, i != 0, -1);
    end
    for (int i = 0; i < 17; i++) begin
      bus_write(2'd0, 32'(8'h10 + i));
    end
    bus_read(2'd1, 32'h0000_1005);
    bus_write(2'd0, 32'h21);
    bus_read(2'd1, 32'h0000_100D);
    bus_write(2'd1, 32'h8);
    bus_read(2'd1, 32'h0000_1005);
    bus_write(2'd2, 32'd2);
    wait_frames(nf);

    // divisor clamp and mid-frame change during data bit 3
    bus_write(2'd2, 32'd0);
    bus_read(2'd2, 32'd2);
    bus_write(2'd2, 32'd4);
    bus_write(2'd0, 32'hC3);
    exp_frame(8'hC3, 4, 8, 5, 0, cyc + 2);
    repeat (18) @(posedge CLK);
    #1;
    bus_write(2'd2, 32'd8);
    wait_frames(nf);

    // reset during data bit 5 with three bytes queued
    bus_write(2'd2, 32'd4);
    for (int i = 0; i < 4; i++) begin
      exp_frame(8'(8'h0F + i), 4, 4, 10, i != 0, -1);
      bus_write(2'd0, 32'(8'h0F + i));
    end
    repeat (23) @(posedge CLK);
    #3;
    chk("pre_reset_line_low", 32'(uart_tx), 32'd0);
    RST = 1'b1;
    #1;
    chk("midframe_reset_uart_tx", 32'(uart_tx), 32'd1);
    chk("midframe_reset_busy", 32'(tx_busy), 32'd0);
    exp_frames.delete();
    @(posedge CLK);
    @(posedge CLK); #1;
    RST = 1'b0;
    nf = frames_done;
    bus_read(2'd1, 32'h0000_0002);
    bus_read(2'd2, 32'd434);

    // 20 bytes through the FIFO, pushing on pop edges across pointer wrap
    bus_write(2'd2, 32'd2);
    base = frames_done;
    for (int i = 0; i < 4; i++) begin
      exp_frame(8'(i * 37 + 5), 2, 2, 10, i != 0, -1);
      bus_write(2'd0, 32'(8'(i * 37 + 5)));
    end
    for (int i = 4; i < 20; i++) begin
      exp_frame(8'(i * 37 + 5), 2, 2, 10, 1, -1);
      wait_frames(base + i - 3);
      bus_write(2'd0, 32'(8'(i * 37 + 5)));
      bus_read(2'd1, 32'h0000_0304);
    end
    wait_frames(base + 20);

    repeat (5) @(posedge CLK);
    #1;
    chk("final_busy", 32'(tx_busy), 32'd0);
    chk("final_frames_pending", 32'(exp_frames.size()), 32'd0);
    bus_read(2'd1, 32'h0000_0002);
    chk("final_reads_pending", 32'(rd_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
